// File: rtl/pio_pattern_master.sv
// Avalon-MM initiator: drives a PIO slave (data/edge-capture/set/clear) from a command stream.
// Optional timeout logic for WAIT_EDGE polling is enabled by defining PIO_MASTER_TIMEOUT_EN.
module pio_pattern_master #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TMO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [TMO_W-1:0]  cmd_timeout,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned CntMax = (READ_LAT > POLL_GAP) ? READ_LAT : POLL_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StGap, StClr, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                accept;
  logic                timed_out;

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef PIO_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Budget runs only while polling and saturates at zero; it is judged at each sample.
  always_comb begin
    tmo_d = tmo_q;
    if (accept) begin
      tmo_d = cmd_timeout;
    end else if ((state_q inside {StRd, StRdWait, StGap}) && (tmo_q != '0)) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign timed_out = (tmo_q == '0);
`else
  logic unused_cmd_timeout;
  assign unused_cmd_timeout = ^cmd_timeout;
  assign timed_out          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    sample_d      = sample_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = (cmd_op == 2'd3) ? StRd : StWr;
        end
      end
      StWr: begin
        if (!avm_waitrequest) begin
          state_d       = StResp;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
        end
      end
      StRd: begin
        if (!avm_waitrequest) begin
          state_d = StRdWait;
          cnt_d   = CntW'(READ_LAT - 1);
        end
      end
      StRdWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (data_q == '0) begin
          state_d       = StResp;
          rsp_data_d    = avm_readdata;
          rsp_timeout_d = 1'b0;
        end else if ((avm_readdata & data_q) != '0) begin
          // Match wins over an expired budget on the same sample.
          state_d  = StClr;
          sample_d = avm_readdata;
        end else if (timed_out) begin
          state_d       = StResp;
          rsp_data_d    = avm_readdata;
          rsp_timeout_d = 1'b1;
        end else begin
          state_d = StGap;
          cnt_d   = CntW'(POLL_GAP - 1);
        end
      end
      StGap: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = StRd;
      end
      StClr: begin
        if (!avm_waitrequest) begin
          state_d       = StResp;
          rsp_data_d    = sample_q;
          rsp_timeout_d = 1'b0;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= '0;
      data_q        <= '0;
      sample_q      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      sample_q      <= sample_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Bus signals decode straight from state so a reset drops the request on the same edge.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    unique case (state_q)
      StWr: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = data_q;
        unique case (op_q)
          2'd1:    avm_address = ADDR_W'(4);
          2'd2:    avm_address = ADDR_W'(5);
          default: avm_address = '0;
        endcase
      end
      StRd: begin
        avm_chipselect = 1'b1;
        avm_address    = ADDR_W'(3);
      end
      StClr: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_W'(3);
        avm_writedata  = sample_q;
      end
      default: ;
    endcase
  end

  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
